// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-op encoding and the alignment rule
// used by the data memory, controller and hazard unit.
package mips_pkg;

  localparam int MEMOP_W = 3;

  localparam logic [MEMOP_W-1:0] MEMOP_WORD  = 3'd0;
  localparam logic [MEMOP_W-1:0] MEMOP_HALF  = 3'd1;
  localparam logic [MEMOP_W-1:0] MEMOP_HALFU = 3'd2;
  localparam logic [MEMOP_W-1:0] MEMOP_BYTE  = 3'd3;
  localparam logic [MEMOP_W-1:0] MEMOP_BYTEU = 3'd4;

  // Codes beyond BYTEU are illegal and always flagged.
  function automatic logic memop_misaligned(input logic [MEMOP_W-1:0] op,
                                            input logic [1:0]         lo);
    logic err;
    case (op)
      MEMOP_WORD:               err = (lo != 2'b00);
      MEMOP_HALF, MEMOP_HALFU:  err = lo[0];
      MEMOP_BYTE, MEMOP_BYTEU:  err = 1'b0;
      default:                  err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_data_ram_if.sv
// MEM-stage data memory bus: EX/MEM-side request fields and the load/align results.
interface mem_data_ram_if;
  import mips_pkg::*;

  logic [31:0]        PCM;
  logic [31:0]        AddrM;
  logic [31:0]        WDataM;
  logic               MemWrM;
  logic [MEMOP_W-1:0] MemOpM;
  logic [31:0]        RDataM;
  logic               AlignErrM;

  modport master (output PCM, AddrM, WDataM, MemWrM, MemOpM,
                  input  RDataM, AlignErrM);
  modport slave  (input  PCM, AddrM, WDataM, MemWrM, MemOpM,
                  output RDataM, AlignErrM);
endinterface

// File: rtl/mem_data_ram_load_ext.sv
// load_ext: picks the addressed half/byte of a memory word and sign- or
// zero-extends it; misaligned or illegal ops read as zero.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0]        word,
  input  logic [1:0]         addr_lo,
  input  logic [MEMOP_W-1:0] memop,
  output logic [31:0]        rdata
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[8*addr_lo +: 8];

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

  always_comb begin
    rdata = '0;
    if (!memop_misaligned(memop, addr_lo)) begin
      case (memop)
        MEMOP_WORD:  rdata = word;
        MEMOP_HALF:  rdata = ext16(half_sel, 1'b1);
        MEMOP_HALFU: rdata = ext16(half_sel, 1'b0);
        MEMOP_BYTE:  rdata = ext8(byte_sel, 1'b1);
        MEMOP_BYTEU: rdata = ext8(byte_sel, 1'b0);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_data_ram.sv
// MEM-stage data memory: lane-masked stores on the clock edge, combinational loads.
// Define MEM_TRACE_EN to print a line for every committed or suppressed store.
module mem_data_ram
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic           clk,
  input  logic           reset,
  mem_data_ram_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word_rd;
  logic [3:0]            lane_en;
  logic [31:0]           wlanes;

  // Upper address bits are dropped, so accesses wrap modulo the depth.
  assign idx       = bus.AddrM[ADDR_WIDTH+1:2];
  assign word_rd   = mem[idx];
  assign bus.AlignErrM = memop_misaligned(bus.MemOpM, bus.AddrM[1:0]);

  // Store data is replicated across lanes so each lane enable picks its own copy.
  always_comb begin
    lane_en = 4'b0000;
    wlanes  = bus.WDataM;
    case (bus.MemOpM)
      MEMOP_WORD: lane_en = 4'b1111;
      MEMOP_HALF, MEMOP_HALFU: begin
        lane_en = bus.AddrM[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{bus.WDataM[15:0]}};
      end
      MEMOP_BYTE, MEMOP_BYTEU: begin
        lane_en = 4'b0001 << bus.AddrM[1:0];
        wlanes  = {4{bus.WDataM[7:0]}};
      end
      default: lane_en = 4'b0000;
    endcase
    if (!bus.MemWrM || bus.AlignErrM) lane_en = 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (lane_en[l]) mem[idx][8*l +: 8] <= wlanes[8*l +: 8];
    end
  end

  load_ext u_load_ext (
    .word    (word_rd),
    .addr_lo (bus.AddrM[1:0]),
    .memop   (bus.MemOpM),
    .rdata   (bus.RDataM)
  );

`ifdef MEM_TRACE_EN
  logic [31:0] merged;

  always_comb begin
    merged = word_rd;
    for (int l = 0; l < 4; l++)
      if (lane_en[l]) merged[8*l +: 8] = wlanes[8*l +: 8];
  end

  always @(posedge clk) begin
    if (reset && bus.MemWrM) begin
      if (bus.AlignErrM)
        $display("@%h: align err %h", bus.PCM, bus.AddrM);
      else
        $display("@%h: *%h <= %h", bus.PCM, {bus.AddrM[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_mem_data_ram.sv
// Bench for mem_data_ram: directed vector table, reset corner sequences and
// random accesses checked against a byte-array reference model.
module tb_mem_data_ram;
  import mips_pkg::*;

  logic clk;
  logic reset;
  mem_data_ram_if bus();

  mem_data_ram #(.ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] mb [16384];

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [2:0] op, logic chk_rd, logic [31:0] rd, logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.op = op;
    v.chk_rd = chk_rd; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] op);
    @(negedge clk);
    bus.PCM    = bus.PCM + 32'd4;
    bus.MemWrM = we;
    bus.AddrM  = addr;
    bus.WDataM = wdata;
    bus.MemOpM = op;
    #1;
  endtask

  function automatic logic ref_err(logic [2:0] op, logic [31:0] a);
    int unsigned lo = a % 4;
    if (op > 4) return 1'b1;
    if (op == 0) return lo != 0;
    if (op == 1 || op == 2) return (lo % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] a);
    int unsigned b = a % 16384;
    longint v;
    if (ref_err(op, a)) return 32'h0;
    case (op)
      3'd0: v = longint'(mb[b]) + 256*longint'(mb[b+1]) + 65536*longint'(mb[b+2])
                + 16777216*longint'(mb[b+3]);
      3'd1, 3'd2: begin
        v = longint'(mb[b]) + 256*longint'(mb[b+1]);
        if (op == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: begin
        v = longint'(mb[b]);
        if (op == 3'd3 && v >= 128) v = v - 256;
      end
    endcase
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned b = a % 16384;
    int n = (op == 0) ? 4 : (op <= 2) ? 2 : 1;
    for (int k = 0; k < n; k++) mb[b+k] = 8'(d >> (8*k));
  endtask

  initial begin
    bus.PCM = 32'h0040_0000; bus.MemWrM = 1'b0; bus.AddrM = '0;
    bus.WDataM = '0; bus.MemOpM = MEMOP_WORD;
    reset = 1'b0;
    foreach (mb[i]) mb[i] = 8'h00;

    // Array held in reset
    repeat (2) @(negedge clk);
    #1;
    check("reset_rdata", bus.RDataM, 32'h0);
    check("reset_alignerr", {31'b0, bus.AlignErrM}, 32'h0);
    reset = 1'b1;

    // Asynchronous clear mid-run, visible before any clock edge
    drive(1'b1, 32'h10, 32'hDEADBEEF, MEMOP_WORD);
    drive(1'b0, 32'h10, 32'h0, MEMOP_WORD);
    check("pre_reset_lw10", bus.RDataM, 32'hDEADBEEF);
    #2 reset = 1'b0;
    #1 check("async_clear_lw10", bus.RDataM, 32'h0);

    // Store edge during reset is dropped
    drive(1'b1, 32'h10, 32'h13579BDF, MEMOP_WORD);
    drive(1'b0, 32'h10, 32'h0, MEMOP_WORD);
    reset = 1'b1;
    #1 check("store_in_reset_dropped", bus.RDataM, 32'h0);

    vecs.push_back(mk(1, 32'h0,    32'h12345678, MEMOP_WORD,  0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h3,    32'h0,        MEMOP_BYTE,  1, 32'h00000012, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        MEMOP_BYTE,  1, 32'h00000078, 0));
    vecs.push_back(mk(0, 32'h2,    32'h0,        MEMOP_HALFU, 1, 32'h00001234, 0));
    vecs.push_back(mk(1, 32'h4,    32'h0000FF80, MEMOP_WORD,  0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h4,    32'h0,        MEMOP_BYTE,  1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h4,    32'h0,        MEMOP_BYTEU, 1, 32'h00000080, 0));
    vecs.push_back(mk(0, 32'h4,    32'h0,        MEMOP_HALF,  1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h4,    32'h0,        MEMOP_HALFU, 1, 32'h0000FF80, 0));
    vecs.push_back(mk(1, 32'h8,    32'hAAAAAAAA, MEMOP_WORD,  0, 32'h0,        0));
    vecs.push_back(mk(1, 32'hA,    32'h00001234, MEMOP_HALF,  0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h9,    32'h00000055, MEMOP_BYTE,  0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h8,    32'h0,        MEMOP_WORD,  1, 32'h123455AA, 0));
    vecs.push_back(mk(1, 32'h6,    32'hCAFEF00D, MEMOP_WORD,  1, 32'h0,        1));
    vecs.push_back(mk(0, 32'h4,    32'h0,        MEMOP_WORD,  1, 32'h0000FF80, 0));
    vecs.push_back(mk(0, 32'h5,    32'h0,        MEMOP_HALF,  1, 32'h0,        1));
    vecs.push_back(mk(1, 32'h400C, 32'h00000001, MEMOP_WORD,  0, 32'h0,        0));
    vecs.push_back(mk(0, 32'hC,    32'h0,        MEMOP_WORD,  1, 32'h00000001, 0));
    vecs.push_back(mk(1, 32'h10,   32'hFFFFFFFF, 3'd6,        1, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   32'h0,        MEMOP_WORD,  1, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        3'd7,        1, 32'h0,        1));
    vecs.push_back(mk(0, 32'h1,    32'h0,        MEMOP_BYTEU, 1, 32'h00000056, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].op);
      check($sformatf("vec%0d_err", i), {31'b0, bus.AlignErrM}, {31'b0, vecs[i].err});
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), bus.RDataM, vecs[i].rd);
    end

    // Reset pulse with no clock edge, then confirm the array stays zeroed
    drive(1'b0, 32'h8, 32'h0, MEMOP_WORD);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check("post_reset_lw8", bus.RDataM, 32'h0);

    // Random accesses against the reference model
    for (int it = 0; it < 600; it++) begin
      logic        we;
      logic [31:0] addr, wdata;
      logic [2:0]  op;
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom & 32'hFFFF_C03F;
      wdata = $urandom;
      op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                          : 3'($urandom_range(0, 4));
      drive(we, addr, wdata, op);
      check("rand_err", {31'b0, bus.AlignErrM}, {31'b0, ref_err(op, addr)});
      check("rand_rdata", bus.RDataM, ref_load(op, addr));
      if (we && !ref_err(op, addr)) ref_store(op, addr, wdata);
    end

    drive(1'b0, 32'h0, 32'h0, MEMOP_WORD);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
